// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter: one shift-add-3 step per clock,
// with the packed BCD result and a display-overflow flag held until the next conversion.
module bin2bcd_seq #(
    parameter int W      = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          bin_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  out_valid,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    bin_q, bin_d;
    logic [BW-1:0]   work_q, work_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            ovf_q, ovf_d;
    logic            vld_q, vld_d;

    logic [BW-1:0]   adj;
    logic            hi_nz;

    // Per-digit +3 correction; digits never carry into each other.
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = work_q[4*i +: 4] + ((work_q[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
        end
    end

    // The display shows four digits; anything in digit 4 and up cannot be shown.
    always_comb begin
        hi_nz = 1'b0;
        for (int i = 4; i < DIGITS; i++) begin
            hi_nz = hi_nz | (|work_q[4*i +: 4]);
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        vld_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d   = bin_in;
                    work_d  = '0;
                    cnt_d   = CW'(W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d = {adj[BW-2:0], bin_q[W-1]};
                bin_d  = bin_q << 1;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = work_q;
                ovf_d   = hi_nz;
                vld_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
        end
    end

    // Gated by rst so a requester never sees ready while the block is held in reset.
    assign in_ready  = rst && (state_q == IDLE);
    assign bcd_out   = bcd_q;
    assign overflow  = ovf_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed scenarios plus randomized values checked
// against a decimal-arithmetic reference.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] bin_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] bcd_out;
    logic        out_valid;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    bin2bcd_seq #(.W(16), .DIGITS(5)) dut (
        .clk(clk), .rst(rst), .bin_in(bin_in), .in_valid(in_valid),
        .in_ready(in_ready), .bcd_out(bcd_out), .out_valid(out_valid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned d;
        r = '0;
        d = 1;
        for (int k = 0; k < 5; k++) begin
            r[k*4 +: 4] = 4'((v / d) % 10);
            d = d * 10;
        end
        return r;
    endfunction

    // Stimulus helper: waits for ready, issues one request, returns what the DUT produced.
    task automatic run_conv(input int unsigned v, output logic [19:0] bcd, output logic ovf,
                            output int lat, output logic width_ok);
        bit got;
        got = 1'b0;
        lat = -1;
        bcd = 'x;
        ovf = 1'bx;
        width_ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin got = 1'b1; break; end
        end
        if (!got) return;
        bin_in = 16'(v);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin lat = n; break; end
        end
        if (lat < 0) return;
        bcd = bcd_out;
        ovf = overflow;
        @(posedge clk);
        #1 width_ok = !out_valid;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bcd_out !== 20'h0) begin n_err++; $display("FAIL reset_bcd: got %h want 00000", bcd_out); end
        n_cmp++; if (out_valid !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL reset_flags: vld=%b ovf=%b want 0 0", out_valid, overflow); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_low: got %b want 0", in_ready); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_after: got %b want 1", in_ready); end
    endtask

    task automatic test_zero;
        logic [19:0] b; logic o; int lat; logic w;
        run_conv(0, b, o, lat, w);
        n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL zero_latency: got %0d want 17", lat); end
        n_cmp++; if (w !== 1'b1) begin n_err++; $display("FAIL zero_pulse_width: second-cycle check %b want 1", w); end
        n_cmp++; if (b !== 20'h00000 || o !== 1'b0) begin n_err++; $display("FAIL zero_result: got %h/%b want 00000/0", b, o); end
    endtask

    task automatic test_boundaries;
        int unsigned vals[3] = '{65535, 9999, 10000};
        logic [19:0] want[3] = '{20'h65535, 20'h09999, 20'h10000};
        logic wovf[3] = '{1'b1, 1'b0, 1'b1};
        logic [19:0] b; logic o; int lat; logic w;
        for (int i = 0; i < 3; i++) begin
            run_conv(vals[i], b, o, lat, w);
            n_cmp++; if (b !== want[i] || o !== wovf[i] || lat !== 17) begin
                n_err++; $display("FAIL boundary_%0d: got %h/%b lat %0d want %h/%b lat 17", vals[i], b, o, lat, want[i], wovf[i]);
            end
        end
    endtask

    task automatic test_ignore_during_shift;
        logic [19:0] prev, cap; int pulses, lat, unstable; logic rdy_busy; bit got;
        prev = bcd_out; pulses = 0; lat = -1; unstable = 0; rdy_busy = 1'b0; cap = 'x; got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin got = 1'b1; break; end
        end
        n_cmp++; if (!got) begin n_err++; $display("FAIL ignore_ready_timeout: in_ready %b want 1", in_ready); end
        bin_in = 16'd1234;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin pulses++; if (lat < 0) begin lat = n; cap = bcd_out; end end
            if (pulses == 0 && bcd_out !== prev) unstable++;
            if (n == 4) begin bin_in = 16'd4321; in_valid = 1'b1; rdy_busy = in_ready; end
            if (n == 7) in_valid = 1'b0;
        end
        n_cmp++; if (rdy_busy !== 1'b0) begin n_err++; $display("FAIL ignore_ready_busy: got %b want 0", rdy_busy); end
        n_cmp++; if (pulses !== 1 || lat !== 17) begin n_err++; $display("FAIL ignore_pulses: got %0d pulses lat %0d want 1 lat 17", pulses, lat); end
        n_cmp++; if (cap !== 20'h01234) begin n_err++; $display("FAIL ignore_result: got %h want 01234", cap); end
        n_cmp++; if (unstable !== 0) begin n_err++; $display("FAIL ignore_stable: %0d cycles changed, want 0", unstable); end
        n_cmp++; if (bcd_out !== 20'h01234) begin n_err++; $display("FAIL ignore_hold: got %h want 01234", bcd_out); end
    endtask

    task automatic test_back_to_back;
        int acc_cyc[$]; logic [19:0] res[$]; bit acc;
        bin_in = 16'd1;
        in_valid = 1'b1;
        for (int c = 0; c < 90 && res.size() < 3; c++) begin
            @(negedge clk);
            acc = in_ready && in_valid;
            @(posedge clk);
            #1;
            if (acc) begin
                acc_cyc.push_back(c);
                bin_in = bin_in + 16'd1;
                if (acc_cyc.size() == 3) in_valid = 1'b0;
            end
            if (out_valid) res.push_back(bcd_out);
        end
        in_valid = 1'b0;
        n_cmp++; if (acc_cyc.size() !== 3 || res.size() !== 3) begin
            n_err++; $display("FAIL b2b_counts: %0d accepts %0d results want 3 3", acc_cyc.size(), res.size());
        end else begin
            n_cmp++; if (acc_cyc[1] - acc_cyc[0] !== 18 || acc_cyc[2] - acc_cyc[1] !== 18) begin
                n_err++; $display("FAIL b2b_spacing: got %0d,%0d want 18,18", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
            end
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (res[i] !== ref_bcd(i + 1)) begin n_err++; $display("FAIL b2b_result_%0d: got %h want %h", i, res[i], ref_bcd(i + 1)); end
            end
        end
    endtask

    task automatic test_reset_abort;
        logic [19:0] b; logic o; int lat; logic w; int pulses; bit got;
        run_conv(255, b, o, lat, w);
        n_cmp++; if (b !== 20'h00255 || o !== 1'b0) begin n_err++; $display("FAIL abort_pre: got %h/%b want 00255/0", b, o); end
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin got = 1'b1; break; end
        end
        n_cmp++; if (!got) begin n_err++; $display("FAIL abort_ready_timeout: in_ready %b want 1", in_ready); end
        bin_in = 16'd777;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (bcd_out !== 20'h0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL abort_in_reset: bcd %h vld %b rdy %b want 00000 0 0", bcd_out, out_valid, in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready_after: got %b want 1", in_ready); end
        pulses = 0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk);
            #1 if (out_valid) pulses++;
        end
        n_cmp++; if (pulses !== 0 || bcd_out !== 20'h0) begin n_err++; $display("FAIL abort_no_pulse: %0d pulses bcd %h want 0 00000", pulses, bcd_out); end
        run_conv(777, b, o, lat, w);
        n_cmp++; if (b !== 20'h00777 || lat !== 17) begin n_err++; $display("FAIL abort_fresh: got %h lat %0d want 00777 lat 17", b, lat); end
    endtask

    task automatic test_random;
        logic [19:0] b; logic o; int lat; logic w; int unsigned v; bit bad;
        for (int i = 0; i < 2000; i++) begin
            v = (i == 0) ? 65535 : (i == 1) ? 0 : $urandom_range(0, 65535);
            run_conv(v, b, o, lat, w);
            n_cmp++; if (b !== ref_bcd(v) || o !== (v > 9999) || lat !== 17 || w !== 1'b1) begin
                n_err++; $display("FAIL random_%0d: got %h/%b lat %0d w %b want %h/%b lat 17 w 1", v, b, o, lat, w, ref_bcd(v), (v > 9999));
            end
            bad = 1'b0;
            for (int k = 0; k < 5; k++) if (b[k*4 +: 4] > 4'd9 || $isunknown(b[k*4 +: 4])) bad = 1'b1;
            n_cmp++; if (bad) begin n_err++; $display("FAIL random_digit_range_%0d: got %h want all digits <= 9", v, b); end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_boundaries();
        test_ignore_during_shift();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
